// File: rtl/lottery_checker.sv
// Lottery ticket checker: digit entry with undo/validation, hit count against SECRET, prize grading, round/win statistics.
// Optional macro LOTTERY_EDGE_DETECT_EN: act only on rising edges of insert/undo/finish (adds one cycle of latency).
module lottery_checker #(
  parameter int NUM_DIGITS = 5,
  parameter int DIGIT_W    = 4,
  parameter int MAX_DIGIT  = 9,
  parameter logic [NUM_DIGITS*DIGIT_W-1:0] SECRET = 20'h50967,
  parameter int P1_HITS    = 4,
  parameter int P2_HITS    = 2,
  parameter int CNT_W      = 8,
  localparam int CW        = $clog2(NUM_DIGITS+1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DIGIT_W-1:0]            digit_in,
  input  logic                          insert,
  input  logic                          undo,
  input  logic                          finish,
  output logic [NUM_DIGITS*DIGIT_W-1:0] digits_out,
  output logic [CW-1:0]                 count,
  output logic [2:0]                    state_out,
  output logic [CW-1:0]                 hits,
  output logic [1:0]                    prize,
  output logic                          win,
  output logic                          err,
  output logic [CNT_W-1:0]              rounds,
  output logic [CNT_W-1:0]              wins
);

  typedef enum logic [1:0] {ENTRY = 2'd0, FULL = 2'd1, EVAL = 2'd2, RESULT = 2'd3} state_t;
  state_t state, state_nx;

  logic               ins, und, fin;
  logic [DIGIT_W-1:0] din;

`ifdef LOTTERY_EDGE_DETECT_EN
  logic ins_q, ins_p, und_q, und_p, fin_q, fin_p;
  logic [DIGIT_W-1:0] din_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      {ins_q, ins_p, und_q, und_p, fin_q, fin_p} <= '0;
      din_q <= '0;
    end else begin
      ins_q <= insert; ins_p <= ins_q;
      und_q <= undo;   und_p <= und_q;
      fin_q <= finish; fin_p <= fin_q;
      din_q <= digit_in;
    end
  end
  assign ins = ins_q & ~ins_p;
  assign und = und_q & ~und_p;
  assign fin = fin_q & ~fin_p;
  assign din = din_q;
`else
  assign ins = insert;
  assign und = undo;
  assign fin = finish;
  assign din = digit_in;
`endif

  logic valid, last, p1, p2;
  int   mc;

  assign valid = (din <= DIGIT_W'(MAX_DIGIT));

  // Full-ticket match count, recomputed from all slots every cycle.
  always_comb begin
    mc = 0;
    for (int k = 0; k < NUM_DIGITS; k++)
      if (digits_out[k*DIGIT_W +: DIGIT_W] == SECRET[k*DIGIT_W +: DIGIT_W]) mc = mc + 1;
  end

  assign last = digits_out[(NUM_DIGITS-1)*DIGIT_W +: DIGIT_W] == SECRET[(NUM_DIGITS-1)*DIGIT_W +: DIGIT_W];
  assign p1   = (mc >= P1_HITS) || ((mc >= P1_HITS-1) && last);
  assign p2   = (mc >= P2_HITS) && last;

  logic [NUM_DIGITS*DIGIT_W-1:0] dig_nx;
  logic [CW-1:0]    cnt_nx, hits_nx;
  logic [1:0]       prize_nx;
  logic             win_nx, err_nx;
  logic [CNT_W-1:0] rounds_nx, wins_nx;
  int               widx;

  always_comb begin
    state_nx  = state;
    dig_nx    = digits_out;
    cnt_nx    = count;
    hits_nx   = hits;
    prize_nx  = prize;
    win_nx    = win;
    err_nx    = 1'b0;
    rounds_nx = rounds;
    wins_nx   = wins;
    widx      = int'(count);
    case (state)
      ENTRY: begin
        if (ins) begin
          if (valid) begin
            dig_nx[widx*DIGIT_W +: DIGIT_W] = din;
            cnt_nx = count + 1'b1;
            if (count == CW'(NUM_DIGITS-1)) state_nx = FULL;
          end else err_nx = 1'b1;
        end else if (und && count != '0) begin
          dig_nx[(widx-1)*DIGIT_W +: DIGIT_W] = '0;
          cnt_nx = count - 1'b1;
        end
      end
      FULL: begin
        if (ins) err_nx = 1'b1;
        else if (und) begin
          dig_nx[(NUM_DIGITS-1)*DIGIT_W +: DIGIT_W] = '0;
          cnt_nx   = CW'(NUM_DIGITS-1);
          state_nx = ENTRY;
        end else if (fin) state_nx = EVAL;
      end
      EVAL: begin
        hits_nx   = CW'(mc);
        prize_nx  = p1 ? 2'd1 : (p2 ? 2'd2 : 2'd0);
        win_nx    = p1 | p2;
        rounds_nx = (&rounds) ? rounds : rounds + 1'b1;
        if ((p1 | p2) && !(&wins)) wins_nx = wins + 1'b1;
        state_nx  = RESULT;
      end
      RESULT: begin
        if (ins) begin
          if (valid) begin
            dig_nx = '0;
            dig_nx[DIGIT_W-1:0] = din;
            cnt_nx   = CW'(1);
            hits_nx  = '0;
            prize_nx = 2'd0;
            win_nx   = 1'b0;
            state_nx = (NUM_DIGITS == 1) ? FULL : ENTRY;
          end else err_nx = 1'b1;
        end
      end
      default: state_nx = ENTRY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ENTRY;
      digits_out <= '0;
      count      <= '0;
      hits       <= '0;
      prize      <= 2'd0;
      win        <= 1'b0;
      err        <= 1'b0;
      rounds     <= '0;
      wins       <= '0;
    end else begin
      state      <= state_nx;
      digits_out <= dig_nx;
      count      <= cnt_nx;
      hits       <= hits_nx;
      prize      <= prize_nx;
      win        <= win_nx;
      err        <= err_nx;
      rounds     <= rounds_nx;
      wins       <= wins_nx;
    end
  end

  assign state_out = {1'b0, state};

endmodule

// File: tb/tb_lottery_checker.sv
// Bench for lottery_checker: table of graded tickets, directed corner sequences, random traffic vs a queue-based model.
module tb_lottery_checker;
  localparam int N = 5;
  localparam logic [19:0] SEC = 20'h50967;

  logic clk = 0, reset = 1, insert = 0, undo = 0, finish = 0;
  logic [3:0]  digit_in = 0;
  logic [19:0] digits_out;
  logic [2:0]  count, hits, state_out;
  logic [1:0]  prize;
  logic        win, err;
  logic [7:0]  rounds, wins;

  lottery_checker dut (
    .clk(clk), .reset(reset), .digit_in(digit_in), .insert(insert), .undo(undo), .finish(finish),
    .digits_out(digits_out), .count(count), .state_out(state_out), .hits(hits), .prize(prize),
    .win(win), .err(err), .rounds(rounds), .wins(wins)
  );

  always #5 clk = ~clk;

  int passed = 0, total = 0;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference model: the ticket is just a list of entered digits.
  int q[$];
  bit m_res, m_evp, m_err;
  int m_hits, m_prize, m_rounds, m_wins;

  function automatic int sec(int k);
    return int'((SEC >> (4*k)) & 20'hF);
  endfunction

  task automatic model_step(bit r, bit i, bit u, bit f, int d);
    int h;
    m_err = 0;
    if (r) begin
      q.delete(); m_res = 0; m_evp = 0;
      m_hits = 0; m_prize = 0; m_rounds = 0; m_wins = 0;
      return;
    end
    if (m_evp) begin
      h = 0;
      for (int k = 0; k < N; k++) if (q[k] == sec(k)) h++;
      m_hits  = h;
      m_prize = (h >= 4 || (h >= 3 && q[N-1] == sec(N-1))) ? 1 :
                (h >= 2 && q[N-1] == sec(N-1)) ? 2 : 0;
      m_rounds = (m_rounds < 255) ? m_rounds + 1 : 255;
      if (m_prize != 0) m_wins = (m_wins < 255) ? m_wins + 1 : 255;
      m_evp = 0; m_res = 1;
      return;
    end
    if (i) begin
      if (d > 9 || (!m_res && q.size() == N)) m_err = 1;
      else begin
        if (m_res) begin q.delete(); m_res = 0; m_hits = 0; m_prize = 0; end
        q.push_back(d);
      end
    end else if (u) begin
      if (!m_res && q.size() > 0) void'(q.pop_back());
    end else if (f) begin
      if (!m_res && q.size() == N) m_evp = 1;
    end
  endtask

  task automatic compare_all();
    logic [19:0] v = '0;
    int st;
    for (int k = 0; k < q.size(); k++) v[k*4 +: 4] = 4'(q[k]);
    st = m_evp ? 2 : m_res ? 3 : (q.size() == N) ? 1 : 0;
    check("digits", digits_out, v);
    check("count", count, q.size());
    check("state", state_out, st);
    check("hits", hits, m_hits);
    check("prize", prize, m_prize);
    check("win", win, m_prize != 0);
    check("err", err, m_err);
    check("rounds", rounds, m_rounds);
    check("wins", wins, m_wins);
  endtask

  task automatic cyc(bit r, bit i, bit u, bit f, int d);
    reset = r; insert = i; undo = u; finish = f; digit_in = 4'(d);
    @(posedge clk); #1;
    reset = 0; insert = 0; undo = 0; finish = 0;
    model_step(r, i, u, f, d);
    compare_all();
  endtask

  task automatic ins(int d);
    cyc(0, 1, 0, 0, d);
  endtask

  task automatic ticket(int a0, int a1, int a2, int a3, int a4);
    ins(a0); ins(a1); ins(a2); ins(a3); ins(a4);
    check("full_before_finish", state_out, 1);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
  endtask

  typedef struct { int d[5]; int h; int p; } vec_t;
  vec_t tbl[8];

  initial begin
    // Secret digits in entry order (slot 0 = LSB nibble): 7,6,9,0,5.
    tbl[0] = '{'{7,6,9,0,5}, 5, 1};
    tbl[1] = '{'{7,6,9,1,5}, 4, 1};
    tbl[2] = '{'{1,1,9,0,5}, 3, 1};
    tbl[3] = '{'{1,1,1,0,5}, 2, 2};
    tbl[4] = '{'{7,6,9,0,1}, 4, 1};
    tbl[5] = '{'{7,6,1,1,1}, 2, 0};
    tbl[6] = '{'{7,6,9,1,1}, 3, 0};
    tbl[7] = '{'{1,1,1,1,5}, 1, 0};

    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    check("rst_state", state_out, 0);
    check("rst_rounds", rounds, 0);

    foreach (tbl[t]) begin
      ticket(tbl[t].d[0], tbl[t].d[1], tbl[t].d[2], tbl[t].d[3], tbl[t].d[4]);
      check($sformatf("tbl%0d_hits", t), hits, tbl[t].h);
      check($sformatf("tbl%0d_prize", t), prize, tbl[t].p);
      check($sformatf("tbl%0d_win", t), win, tbl[t].p != 0);
    end
    check("tbl_rounds", rounds, 8);
    check("tbl_wins", wins, 5);

    // Invalid insert in RESULT keeps results.
    ins(12);
    check("res_bad_err", err, 1);
    check("res_bad_state", state_out, 3);

    // Entry-side error pulse and undo.
    cyc(1, 0, 0, 0, 0);
    ins(12);
    check("bad_err", err, 1);
    check("bad_cnt", count, 0);
    cyc(0, 0, 0, 0, 0);
    check("bad_err_clear", err, 0);
    ins(3);
    cyc(0, 0, 1, 0, 0);
    check("undo_cnt", count, 0);
    check("undo_digits", digits_out, 0);
    cyc(0, 0, 1, 0, 0);
    check("undo0_err", err, 0);
    check("undo0_cnt", count, 0);

    // FULL corner cases.
    ins(1); ins(2); ins(3); ins(4); ins(5);
    check("fill_state", state_out, 1);
    cyc(0, 0, 1, 0, 0);
    check("full_undo_state", state_out, 0);
    check("full_undo_cnt", count, 4);
    ins(7);
    check("refill_state", state_out, 1);
    ins(3);
    check("full_ins_err", err, 1);
    cyc(0, 1, 0, 1, 2);
    check("ins_fin_err", err, 1);
    check("ins_fin_state", state_out, 1);
    cyc(0, 0, 0, 0, 0);
    check("ins_fin_stay", state_out, 1);

    // Reset mid-operation.
    cyc(1, 0, 0, 0, 0);
    ins(4); ins(5); ins(6);
    cyc(1, 0, 0, 0, 0);
    check("rst_entry_cnt", count, 0);
    check("rst_entry_dig", digits_out, 0);
    ticket(7,6,9,0,5);
    ticket(1,1,1,0,5);
    check("pre_rst_rounds", rounds, 2);
    cyc(1, 0, 0, 0, 0);
    check("rst_res_rounds", rounds, 0);
    check("rst_res_wins", wins, 0);
    check("rst_res_state", state_out, 0);

    // Saturation.
    for (int r = 0; r < 260; r++) ticket(r % 10, 6, 9, 0, 5);
    check("sat_rounds", rounds, 255);

    // Random traffic against the model.
    cyc(1, 0, 0, 0, 0);
    for (int n = 0; n < 1500; n++) begin
      int sel, d, slot;
      bit r, i, u, f;
      sel  = $urandom_range(0, 99);
      slot = (m_res || q.size() >= N) ? 0 : q.size();
      d    = $urandom_range(0, 1) ? sec(slot) : $urandom_range(0, 15);
      r = (sel == 0);
      i = (sel >= 1 && sel < 50) || (sel >= 95);
      u = (sel >= 50 && sel < 62) || (sel >= 97);
      f = (sel >= 62 && sel < 95) || (sel >= 98);
      cyc(r, i, u, f, d);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
